// File: rtl/pipe_ripple_adder_if.sv
// Valid/ready handshake bundle for pipe_ripple_adder: operand side plus result side.
// master = producer/consumer environment, slave = the adder.
interface pipe_ripple_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );
endinterface

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple adder: WIDTH bits split into STAGES segments, one segment per stage, valid/ready flow.
// Optional unsigned saturation on the final carry: define PIPE_RIPPLE_ADDER_SAT_EN.
module pipe_ripple_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipe_ripple_adder_if.slave   bus
);
   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipe_ripple_adder: WIDTH must be a positive multiple of STAGES");
   end

   localparam int SEG = WIDTH / STAGES;

   // Operands travel with the partial sum so every segment meets its own bits one stage later.
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] sum;
      logic             carry;
   } stage_t;

   stage_t stage_q [STAGES];
   stage_t stage_d [STAGES];
   stage_t src     [STAGES];
   logic   advance;

   function automatic stage_t stage_step(input int s, input stage_t in_slot);
      stage_t       nxt;
      logic [SEG:0] seg;
      seg = {1'b0, in_slot.a[s*SEG +: SEG]} + {1'b0, in_slot.b[s*SEG +: SEG]}
          + {{SEG{1'b0}}, in_slot.carry};
      nxt       = in_slot;
      nxt.carry = seg[SEG];
`ifdef PIPE_RIPPLE_ADDER_SAT_EN
      if (s == STAGES - 1 && seg[SEG]) nxt.sum = '1;
      else                             nxt.sum[s*SEG +: SEG] = seg[SEG-1:0];
`else
      nxt.sum[s*SEG +: SEG] = seg[SEG-1:0];
`endif
      return nxt;
   endfunction

   // The whole pipe moves as one: either every stage shifts or every stage holds.
   assign advance = !stage_q[STAGES-1].valid || bus.out_ready;

   always_comb begin
      src[0] = '{valid: bus.in_valid, a: bus.in_a, b: bus.in_b, sum: '0, carry: bus.in_cin};
      for (int s = 1; s < STAGES; s++) src[s] = stage_q[s-1];

      for (int s = 0; s < STAGES; s++) begin
         // NOTE: default to hold first so no path through this block leaves stage_d unassigned (no latch).
         stage_d[s] = stage_q[s];
         if (advance) begin
            if (src[s].valid) stage_d[s]       = stage_step(s, src[s]);
            else              stage_d[s].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: datapath registers are reset too, not only valid bits, so out_sum reads 0 out of reset.
         for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
      end else begin
         // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
         for (int s = 0; s < STAGES; s++) stage_q[s] <= stage_d[s];
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = stage_q[STAGES-1].valid;
   assign bus.out_sum   = stage_q[STAGES-1].sum;
   assign bus.out_cout  = stage_q[STAGES-1].carry;
endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Directed bench for pipe_ripple_adder: 16-bit/4-stage instance plus an 8-bit/1-stage instance.
// Expected sums follow PIPE_RIPPLE_ADDER_SAT_EN when it is defined.
module tb_pipe_ripple_adder;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   pipe_ripple_adder_if #(.WIDTH(16)) bus16 ();
   pipe_ripple_adder_if #(.WIDTH(8))  bus8 ();

   pipe_ripple_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   pipe_ripple_adder #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One operand into an empty pipe with out_ready high; result must show exactly 4 cycles later.
   task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
      bus16.in_valid = 1'b1;
      bus16.in_a     = a;
      bus16.in_b     = b;
      bus16.in_cin   = cin;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 1) begin
            bus16.in_valid = 1'b0;
            bus16.in_a     = 16'hDEAD;
            bus16.in_b     = 16'hBEEF;
         end
         check($sformatf("%s_valid_c%0d", tag, k), bus16.out_valid, (k == 4));
         if (k == 4) begin
            check($sformatf("%s_sum", tag), bus16.out_sum, exp_sum);
            check($sformatf("%s_cout", tag), bus16.out_cout, exp_cout);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] op_a [6];
      logic [15:0] op_b [6];
      logic [15:0] exp_stall [6];
      int          next_op;
      int          n_pop;

      rst_n          = 1'b0;
      bus16.in_valid = 1'b0;
      bus16.in_a     = '0;
      bus16.in_b     = '0;
      bus16.in_cin   = 1'b0;
      bus16.out_ready = 1'b1;
      bus8.in_valid  = 1'b0;
      bus8.in_a      = '0;
      bus8.in_b      = '0;
      bus8.in_cin    = 1'b0;
      bus8.out_ready = 1'b1;

      // Reset state
      step();
      step();
      check("rst_out_valid", bus16.out_valid, 1'b0);
      check("rst_out_sum", bus16.out_sum, 16'h0000);
      check("rst_out_cout", bus16.out_cout, 1'b0);
      check("rst_in_ready", bus16.in_ready, 1'b1);
      check("rst_in_ready8", bus8.in_ready, 1'b1);
      rst_n = 1'b1;
      step();
      check("post_rst_in_ready", bus16.in_ready, 1'b1);
      check("post_rst_out_valid", bus16.out_valid, 1'b0);

      // Latency and cross-segment carry
      run_single("lat", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
`ifdef PIPE_RIPPLE_ADDER_SAT_EN
      run_single("ripple_all", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
`else
      run_single("ripple_all", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
`endif
      run_single("mid", 16'h1234, 16'h0FCC, 1'b1, 16'h2201, 1'b0);

      // Back-to-back operands (i, 2i): results 3i on consecutive cycles 4..11
      bus16.in_valid = 1'b1;
      bus16.in_a     = 16'd0;
      bus16.in_b     = 16'd0;
      bus16.in_cin   = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step();
         if (k < 8) begin
            bus16.in_a = 16'(k);
            bus16.in_b = 16'(2 * k);
         end else begin
            bus16.in_valid = 1'b0;
         end
         check($sformatf("b2b_valid_c%0d", k), bus16.out_valid, (k >= 4 && k <= 11));
         if (k >= 4 && k <= 11)
            check($sformatf("b2b_sum_c%0d", k), bus16.out_sum, 16'(3 * (k - 4)));
      end

      // Stall: out_ready low in cycles 5..8 while a 6-operand stream is offered
      for (int i = 0; i < 6; i++) begin
         op_a[i]      = 16'h1111 * 16'(i);
         op_b[i]      = 16'h0F0F + 16'(i);
         exp_stall[i] = op_a[i] + op_b[i];
      end
      next_op = 0;
      n_pop   = 0;
      for (int c = 0; c < 20; c++) begin
         bus16.out_ready = !(c >= 5 && c <= 8);
         if (next_op < 6) begin
            bus16.in_valid = 1'b1;
            bus16.in_a     = op_a[next_op];
            bus16.in_b     = op_b[next_op];
         end else begin
            bus16.in_valid = 1'b0;
         end
         #1;
         if (c >= 5 && c <= 8) begin
            check($sformatf("stall_in_ready_c%0d", c), bus16.in_ready, 1'b0);
            check($sformatf("stall_out_valid_c%0d", c), bus16.out_valid, 1'b1);
            check($sformatf("stall_hold_sum_c%0d", c), bus16.out_sum, exp_stall[1]);
         end
         if (bus16.out_valid && bus16.out_ready) begin
            if (n_pop < 6) check($sformatf("stall_order%0d", n_pop), bus16.out_sum, exp_stall[n_pop]);
            else           check("stall_extra_result", 1'b1, 1'b0);
            n_pop++;
         end
         if (bus16.in_valid && bus16.in_ready) next_op++;
         step();
      end
      bus16.out_ready = 1'b1;
      check("stall_pop_count", n_pop, 6);
      check("stall_accept_count", next_op, 6);

      // Reset with three operands in flight
      bus16.in_cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus16.in_valid = 1'b1;
         bus16.in_a     = 16'h0100 + 16'(i);
         bus16.in_b     = 16'h0001;
         step();
      end
      bus16.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus16.out_valid, 1'b0);
      check("midrst_out_sum", bus16.out_sum, 16'h0000);
      check("midrst_in_ready", bus16.in_ready, 1'b1);
      step();
      rst_n = 1'b1;
      check("midrst_rel_out_valid", bus16.out_valid, 1'b0);
      run_single("after_rst", 16'h4000, 16'h0321, 1'b0, 16'h4321, 1'b0);

      // Single-stage 8-bit instance
      bus8.in_valid = 1'b1;
      bus8.in_a     = 8'h80;
      bus8.in_b     = 8'h80;
      bus8.in_cin   = 1'b1;
      step();
      bus8.in_valid = 1'b0;
      check("s1_valid", bus8.out_valid, 1'b1);
`ifdef PIPE_RIPPLE_ADDER_SAT_EN
      check("s1_sum", bus8.out_sum, 8'hFF);
`else
      check("s1_sum", bus8.out_sum, 8'h01);
`endif
      check("s1_cout", bus8.out_cout, 1'b1);
      step();
      check("s1_valid_drop", bus8.out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_ripple_adder.md
PIPE_RIPPLE_ADDER -- requirements
Module: pipe_ripple_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline segments; legal only if STAGES >= 1 and WIDTH % STAGES == 0; SEG = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand set offered.
REQ-006 SHALL have port in_ready, output, 1, operand set accepted when in_valid && in_ready at a clk edge.
REQ-007 SHALL have port in_a, input, WIDTH, operand A (unsigned).
REQ-008 SHALL have port in_b, input, WIDTH, operand B (unsigned).
REQ-009 SHALL have port in_cin, input, 1, carry-in.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts when out_valid && out_ready at a clk edge.
REQ-012 SHALL have port out_sum, output, WIDTH, result sum.
REQ-013 SHALL have port out_cout, output, 1, carry-out of bit WIDTH-1.

Function
REQ-014 SHALL compute {out_cout, out_sum} = in_a + in_b + in_cin, exact modulo 2^(WIDTH+1).
REQ-015 SHALL split the addition into STAGES segments of SEG bits; stage s adds bits [s*SEG +: SEG] plus the carry registered by stage s-1 (stage 0 uses in_cin).
REQ-016 SHALL carry unused upper operand bits and completed lower sum bits forward through per-stage registers (operand skew), so that all WIDTH sum bits emerge together.
REQ-017 SHALL have latency exactly STAGES cycles from accepting handshake to out_valid when out_ready is held high.
REQ-018 SHALL sustain throughput of one result per cycle when out_ready is held high.
REQ-019 SHALL keep one valid bit per stage; bubbles (in_valid low) propagate as invalid slots and never produce out_valid.
REQ-020 SHALL drive in_ready = !out_valid || out_ready (combinational); when in_ready is low, all stage registers and valid bits SHALL hold.
REQ-021 SHALL hold out_sum, out_cout and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, on a simultaneous output pop and input accept, advance the whole pipeline in the same cycle with no lost or duplicated result.
REQ-023 SHALL, with STAGES == 1, behave as a single registered adder with latency 1.
REQ-024 SHALL ignore in_a/in_b/in_cin when the handshake does not fire.

Reset
REQ-025 SHALL, while rst_n is low, force all stage valid bits to 0, out_valid to 0, out_sum to 0, out_cout to 0, and all carry/skew registers to 0.
REQ-026 SHALL drive in_ready = 1 during and immediately after reset.
REQ-027 SHALL discard all in-flight operands when rst_n asserts mid-operation; no result for them ever appears.

Configuration
REQ-028 SHALL compile unsigned saturation in when macro PIPE_RIPPLE_ADDER_SAT_EN is defined: if the final carry is 1, out_sum SHALL be all-ones and out_cout SHALL still be 1.
REQ-029 SHALL, without PIPE_RIPPLE_ADDER_SAT_EN, output the wrapped sum per REQ-014 with no saturation logic present.

Verification
REQ-030 SHALL cover: WIDTH=16, STAGES=4, in_a=0x00FF, in_b=0x0001, in_cin=0, out_ready=1 -> out_valid exactly 4 cycles later, out_sum=0x0100, out_cout=0.
REQ-031 SHALL cover: in_a=0xFFFF, in_b=0x0000, in_cin=1 (carry across all segments) -> out_sum=0x0000, out_cout=1; with PIPE_RIPPLE_ADDER_SAT_EN -> out_sum=0xFFFF, out_cout=1.
REQ-032 SHALL cover: 8 back-to-back operand sets (i, 2*i) for i=0..7 with out_ready=1 -> results 3*i on 8 consecutive cycles starting cycle 4.
REQ-033 SHALL cover: stream of 6 operands with out_ready low for cycles 5-8 -> in_ready low in those cycles while out_valid high, output held stable, all 6 results delivered in order, none lost or duplicated.
REQ-034 SHALL cover: rst_n pulsed low for 1 cycle with 3 operands in flight -> out_valid=0, out_sum=0 after reset, none of the 3 results appear, next accepted operand appears after 4 cycles.
REQ-035 SHALL cover: STAGES=1, WIDTH=8, in_a=0x80, in_b=0x80, in_cin=1 -> out_sum=0x01, out_cout=1 one cycle later.
